// File: rtl/game_pkg.sv
// game_pkg: piece-sequencing state enum and default timing constants shared by the game timing blocks
package game_pkg;
  typedef enum logic [1:0] {FALL, LAND, LOCK, SETTLE} drop_state_t;
  localparam int DEF_BASE_PERIOD = 10_000_000;
  localparam int DEF_STEP        = 800_000;
  localparam int DEF_MIN_PERIOD  = 500_000;
  localparam int DEF_SOFT_PERIOD = 1_000_000;
  localparam int DEF_LOCK_TICKS  = 2;
  localparam int DEF_MAX_RESETS  = 15;
  localparam int DEF_CNT_W       = 32;
endpackage

// File: rtl/drop_scheduler_if.sv
// drop_scheduler_if: control inputs and fall/lock/spawn outputs between game logic and the drop scheduler
interface drop_scheduler_if;
  logic       pause;
  logic [3:0] level;
  logic       soft_drop;
  logic       hard_drop;
  logic       grounded;
  logic       piece_moved;
  logic       lock_ack;
  logic       clear_busy;
  logic       fall;
  logic       lock_req;
  logic       spawn;
  modport master (
    output pause, level, soft_drop, hard_drop, grounded, piece_moved, lock_ack, clear_busy,
    input  fall, lock_req, spawn
  );
  modport slave (
    input  pause, level, soft_drop, hard_drop, grounded, piece_moved, lock_ack, clear_busy,
    output fall, lock_req, spawn
  );
endinterface

// File: rtl/drop_scheduler_tick_counter.sv
// tick_counter: free-running period counter that ticks once cnt reaches period-1 and then wraps to 0
module tick_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  // >= rather than == so a period that shrinks below cnt ticks next cycle instead of wrapping
  assign tick = en && cnt >= period - CNT_W'(1);
  // count enabled cycles, wrap on tick, forced clear wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/drop_scheduler.sv
// drop_scheduler: level-dependent gravity, lock delay and lock/spawn sequencing for the active piece
module drop_scheduler
  import game_pkg::*;
#(
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP        = DEF_STEP,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int SOFT_PERIOD = DEF_SOFT_PERIOD,
  parameter int LOCK_TICKS  = DEF_LOCK_TICKS,
  parameter int MAX_RESETS  = DEF_MAX_RESETS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst_n,
  drop_scheduler_if.slave bus
);
  localparam int PW = CNT_W + 4;
  localparam int LW = $clog2(LOCK_TICKS + 2);
  localparam int RW = $clog2(MAX_RESETS + 2);
  localparam logic [LW-1:0] LT = LW'(LOCK_TICKS);
  localparam logic [RW-1:0] MR = RW'(MAX_RESETS);
  drop_state_t   state, state_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [RW-1:0] resets, resets_n;
  logic [PW-1:0] dec, g, p;
  logic          run, tick, clr, fall_n, spawn_n;
  assign run = !bus.pause;
  // gravity period, clamped to MIN_PERIOD before the subtraction can underflow, capped while soft dropping
  always_comb begin
    dec = PW'(bus.level) * PW'(STEP);
    g   = dec >= PW'(BASE_PERIOD - MIN_PERIOD) ? PW'(MIN_PERIOD) : PW'(BASE_PERIOD) - dec;
    p   = bus.soft_drop && g > PW'(SOFT_PERIOD) ? PW'(SOFT_PERIOD) : g;
  end
  tick_counter #(.CNT_W(CNT_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (run),
    .clr    (clr),
    .period (CNT_W'(p)),
    .tick   (tick)
  );
  // next state: hard_drop beats tick beats piece_moved; lock_ack is honoured even while paused
  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    resets_n   = resets;
    fall_n     = 1'b0;
    spawn_n    = 1'b0;
    clr        = 1'b0;
    case (state)
      FALL, LAND: if (run) begin
        if (bus.hard_drop) state_n = LOCK;
        else if (tick) begin
          if (!bus.grounded) begin
            fall_n  = 1'b1;
            state_n = FALL;
          end else if (state == FALL) begin
            state_n    = LAND;
            lock_cnt_n = '0;
          end else begin
            lock_cnt_n = lock_cnt + LW'(1);
            if (lock_cnt_n == LT) state_n = LOCK;
          end
        end else if (state == LAND && bus.piece_moved && resets < MR) begin
          clr        = 1'b1;
          lock_cnt_n = '0;
          resets_n   = resets + RW'(1);
        end
      end
      LOCK: if (bus.lock_ack) state_n = SETTLE;
      SETTLE: if (run && !bus.clear_busy) begin
        spawn_n    = 1'b1;
        clr        = 1'b1;
        lock_cnt_n = '0;
        resets_n   = '0;
        state_n    = FALL;
      end
      default: state_n = FALL;
    endcase
  end
  // state and registered outputs; lock_req follows the registered state so it drops the cycle after the ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= FALL;
      lock_cnt     <= '0;
      resets       <= '0;
      bus.fall     <= 1'b0;
      bus.lock_req <= 1'b0;
      bus.spawn    <= 1'b0;
    end else begin
      state        <= state_n;
      lock_cnt     <= lock_cnt_n;
      resets       <= resets_n;
      bus.fall     <= fall_n;
      bus.lock_req <= state_n == LOCK;
      bus.spawn    <= spawn_n;
    end
endmodule

// File: tb/tb_drop_scheduler.sv
// tb_drop_scheduler: scoreboard bench with directed timing checks and randomized stimulus against a reference model
module tb_drop_scheduler;
  localparam int BP = 100, ST = 10, MP = 20, SP = 15, LTK = 2, MRS = 3;
  localparam int PH_FALLING = 0, PH_LANDED = 1, PH_LOCKING = 2, PH_SETTLING = 3;
  logic clk = 1'b0;
  logic rst_n;
  int n_tests = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];
  int m_phase, m_cnt, m_ground_ticks, m_resets;
  drop_scheduler_if bus();
  drop_scheduler #(
    .BASE_PERIOD(BP), .STEP(ST), .MIN_PERIOD(MP), .SOFT_PERIOD(SP),
    .LOCK_TICKS(LTK), .MAX_RESETS(MRS), .CNT_W(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  function automatic int period_of(int lvl, bit sd);
    int g;
    g = BP - lvl * ST;
    if (g < MP) g = MP;
    if (sd && g > SP) g = SP;
    return g;
  endfunction
  // reference: what the outputs must be after the coming clock edge, given the inputs applied now
  function automatic void model_step();
    bit tick, ef, es;
    ef = 0;
    es = 0;
    if (!rst_n) begin
      m_phase = PH_FALLING;
      m_cnt = 0;
      m_ground_ticks = 0;
      m_resets = 0;
      exp_q.push_back(3'b000);
      return;
    end
    tick = !bus.pause && m_cnt >= period_of(int'(bus.level), bus.soft_drop) - 1;
    if (!bus.pause) m_cnt = tick ? 0 : m_cnt + 1;
    if ((m_phase == PH_FALLING || m_phase == PH_LANDED) && !bus.pause) begin
      if (bus.hard_drop) m_phase = PH_LOCKING;
      else if (tick) begin
        if (!bus.grounded) begin
          ef = 1;
          m_phase = PH_FALLING;
        end else if (m_phase == PH_FALLING) begin
          m_phase = PH_LANDED;
          m_ground_ticks = 0;
        end else begin
          m_ground_ticks++;
          if (m_ground_ticks == LTK) m_phase = PH_LOCKING;
        end
      end else if (m_phase == PH_LANDED && bus.piece_moved && m_resets < MRS) begin
        m_cnt = 0;
        m_ground_ticks = 0;
        m_resets++;
      end
    end else if (m_phase == PH_LOCKING) begin
      if (bus.lock_ack) m_phase = PH_SETTLING;
    end else if (m_phase == PH_SETTLING && !bus.pause && !bus.clear_busy) begin
      es = 1;
      m_cnt = 0;
      m_ground_ticks = 0;
      m_resets = 0;
      m_phase = PH_FALLING;
    end
    exp_q.push_back({ef, m_phase == PH_LOCKING, es});
  endfunction
  // monitor: every cycle the DUT outputs must match the next scoreboard entry
  always @(negedge clk) begin
    logic [2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fall, bus.lock_req, bus.spawn} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t fall/lock_req/spawn got %b want %b", $time,
                 {bus.fall, bus.lock_req, bus.spawn}, e);
      end
    end
  end
  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  function automatic bit out_bit(int which);
    return which == 0 ? bus.fall : which == 1 ? bus.lock_req : bus.spawn;
  endfunction
  // cycles until the chosen output is seen high; -1 if the budget expires
  task automatic run_until(input int which, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick_cycle();
      if (out_bit(which)) begin
        n = i;
        return;
      end
    end
  endtask
  task automatic do_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, int'({bus.fall, bus.lock_req, bus.spawn}), 0);
    repeat (3) tick_cycle();
    rst_n = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, sp;
    rst_n = 1'b0;
    bus.pause = 0; bus.level = 0; bus.soft_drop = 0; bus.hard_drop = 0;
    bus.grounded = 0; bus.piece_moved = 0; bus.lock_ack = 0; bus.clear_busy = 0;
    repeat (3) tick_cycle();
    check("reset_outputs", int'({bus.fall, bus.lock_req, bus.spawn}), 0);
    rst_n = 1'b1;
    run_until(0, 150, n); check("first_fall_l0", n, 100);
    run_until(0, 150, n); check("fall2_l0", n, 100);
    run_until(0, 150, n); check("fall3_l0", n, 100);
    bus.level = 5;  run_until(0, 150, n); check("period_l5", n, 50);
    bus.level = 9;  run_until(0, 150, n); check("period_l9", n, 20);
    bus.level = 15; run_until(0, 150, n); check("period_l15", n, 20);
    bus.level = 0; bus.soft_drop = 1; run_until(0, 150, n); check("period_soft", n, 15);
    bus.soft_drop = 0; run_until(0, 150, n); check("period_l0_again", n, 100);
    bus.grounded = 1;
    run_until(1, 400, n); check("lock_delay", n, 300);
    bus.lock_ack = 1; tick_cycle(); bus.lock_ack = 0;
    check("lock_req_drop", int'(bus.lock_req), 0);
    run_until(2, 10, n); check("ack_to_spawn", n + 1, 2);
    run_until(1, 400, n); check("lock_delay2", n, 300);
    bus.clear_busy = 1; bus.lock_ack = 1; tick_cycle(); bus.lock_ack = 0;
    repeat (39) tick_cycle();
    bus.clear_busy = 0;
    run_until(2, 10, n); check("spawn_after_busy", n, 1);
    repeat (100) tick_cycle();
    for (int r = 0; r < 4; r++) begin
      repeat (89) tick_cycle();
      bus.piece_moved = 1; tick_cycle(); bus.piece_moved = 0;
    end
    run_until(1, 400, n); check("lock_after_resets", n, 110);
    bus.lock_ack = 1; tick_cycle(); bus.lock_ack = 0;
    run_until(2, 10, n); check("spawn_after_resets", n, 1);
    repeat (150) tick_cycle();
    bus.grounded = 0;
    run_until(0, 200, n); check("fall_from_land", n, 50);
    run_until(0, 200, n); check("fall_after_land", n, 100);
    repeat (99) tick_cycle();
    bus.hard_drop = 1; tick_cycle(); bus.hard_drop = 0;
    check("hard_drop_lock", int'(bus.lock_req), 1);
    check("hard_drop_nofall", int'(bus.fall), 0);
    bus.pause = 1; bus.lock_ack = 1; tick_cycle(); bus.lock_ack = 0;
    check("ack_in_pause", int'(bus.lock_req), 0);
    sp = 0;
    for (int i = 0; i < 20; i++) begin
      tick_cycle();
      sp += int'(bus.spawn);
    end
    check("spawn_held_in_pause", sp, 0);
    bus.pause = 0;
    run_until(2, 10, n); check("spawn_on_unpause", n, 1);
    repeat (50) tick_cycle();
    bus.pause = 1; repeat (1000) tick_cycle(); bus.pause = 0;
    run_until(0, 200, n); check("fall_after_pause", n, 50);
    bus.hard_drop = 1; tick_cycle(); bus.hard_drop = 0;
    check("lock_before_reset", int'(bus.lock_req), 1);
    do_reset("reset_in_lock");
    run_until(0, 150, n); check("fall_after_reset_lock", n, 100);
    bus.grounded = 1;
    repeat (130) tick_cycle();
    do_reset("reset_in_land");
    bus.grounded = 0;
    run_until(0, 150, n); check("fall_after_reset_land", n, 100);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) bus.level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) bus.soft_drop = ~bus.soft_drop;
      if ($urandom_range(0, 99) < 3) bus.grounded = ~bus.grounded;
      if ($urandom_range(0, 99) < 10) bus.clear_busy = ~bus.clear_busy;
      bus.pause = $urandom_range(0, 99) < 5;
      bus.hard_drop = $urandom_range(0, 199) < 1;
      bus.piece_moved = $urandom_range(0, 99) < 8;
      bus.lock_ack = $urandom_range(0, 99) < 30;
      tick_cycle();
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
